// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared encodings and the round-robin pick for the 2:1 packet arbiter.
// Used by bus_arbiter_2to1 and bus_arb_out_reg.
package bus_arbiter_2to1_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  // On contention the requester that did not win last time is chosen.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
    logic pick;
    if (v0 && v1) begin
      pick = ~last_grant;
    end else if (v1) begin
      pick = GRANT_REQ1;
    end else begin
      pick = GRANT_REQ0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_arb_out_reg.sv
// One-entry valid/ready output slice holding {last, data}.
// A load always wins over a drain, so a simultaneous drain+load keeps the slice full.
module bus_arb_out_reg
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  logic             r_valid;
  logic [WIDTH:0]   r_payload;

  // The caller only asserts i_load when the slot is free or draining, so the
  // payload is never overwritten while it is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= {i_last, i_data};
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_payload[WIDTH-1:0];
  assign o_last  = r_payload[WIDTH];

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 packet arbiter with grant locked until the last beat is accepted.
// Optional per-requester packet grant counters: define ARB_GRANT_CNT_EN.
module bus_arbiter_2to1
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
`endif
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic             r_sel;
  logic             r_busy;
  logic             r_last_grant;

  logic             w_slot_free;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_load;
  logic [WIDTH-1:0] w_load_data;
  logic             w_load_last;
  logic             w_start;
  logic             w_pick;

  // Ready depends only on state and out_ready, never on req*_valid.
  assign w_slot_free = ~out_valid | out_ready;
  assign req0_ready  = (r_state == ST_BUSY0) & w_slot_free;
  assign req1_ready  = (r_state == ST_BUSY1) & w_slot_free;

  assign w_acc0 = req0_valid & req0_ready;
  assign w_acc1 = req1_valid & req1_ready;
  assign w_load = w_acc0 | w_acc1;

  assign w_load_data = (r_state == ST_BUSY1) ? req1_data : req0_data;
  assign w_load_last = (r_state == ST_BUSY1) ? req1_last : req0_last;

  assign w_start = (r_state == ST_IDLE) & (req0_valid | req1_valid);
  assign w_pick  = rr_pick(req0_valid, req1_valid, r_last_grant);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_d = (w_pick == GRANT_REQ1) ? ST_BUSY1 : ST_BUSY0;
        end
      end
      ST_BUSY0: begin
        if (w_acc0 && req0_last) begin
          w_state_d = ST_IDLE;
        end
      end
      ST_BUSY1: begin
        if (w_acc1 && req1_last) begin
          w_state_d = ST_IDLE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // last_grant resets to REQ1 so that REQ0 wins the first contended arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= GRANT_REQ0;
      r_busy       <= 1'b0;
      r_last_grant <= GRANT_REQ1;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_sel        <= w_pick;
        r_busy       <= 1'b1;
        r_last_grant <= w_pick;
      end else if (w_load && w_load_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign sel  = r_sel;
  assign busy = r_busy;

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] r_grant0_cnt;
  logic [CNT_W-1:0] r_grant1_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
    end else if (w_start) begin
      if (w_pick == GRANT_REQ1) begin
        r_grant1_cnt <= r_grant1_cnt + 1'b1;
      end else begin
        r_grant0_cnt <= r_grant0_cnt + 1'b1;
      end
    end
  end

  assign grant0_cnt = r_grant0_cnt;
  assign grant1_cnt = r_grant1_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

  bus_arb_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_last  (w_load_last),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_last  (out_last)
  );

endmodule
